// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB responder backed by a word-organised memory.
//
// Accepts AHB address phases (hsel & hreadyin & htrans[1]), inserts
// WAIT_STATES low-hreadyout cycles before each OKAY data phase, supports
// byte/halfword/word writes with lane enables, and answers out-of-range,
// oversized or misaligned accesses with a two-cycle ERROR response.
//
// Optional feature macro: AHB_SLV_WRITE_PROT_EN
//   When defined, the top quarter of the memory (word index >= 3/4 depth)
//   is read-only; writes there get an ERROR response and do not commit.
//
// Ports:
//   hclk       clock, all logic on posedge
//   hresetn    asynchronous reset, active-high
//   hsel       slave select
//   htrans     transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite     1 = write
//   hreadyin   bus ready from the previous transfer
//   haddr      byte address
//   hburst     burst type (ignored)
//   hsize      000 byte, 001 half, 010 word
//   hwdata     write data (data phase)
//   hreadyout  data phase complete when 1
//   hresp      00 OKAY, 01 ERROR
//   hrdata     read data (zero outside a read data phase)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transfer in progress, hreadyout=1, OKAY
// WAIT  | OKAY transfer stalled, hreadyout=0, counts down wait states
// DATA  | OKAY data phase completes this cycle; write commits at its end
// ERR1  | first ERROR cycle, hreadyout=0, hresp=01
// ERR2  | second ERROR cycle, hreadyout=1, hresp=01
module ahb_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic        hreadyin,
    input  logic [31:0] haddr,
    input  logic [2:0]  hburst,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t        state;
    state_t        accept_state;
    logic [3:0]    wait_cnt;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [1:0]    size_q;
    logic [3:0]    lane_en;
    logic [31:0]   mem [MEM_DEPTH];

    logic accept;
    logic in_range;
    logic bad_size;
    logic misalign;
    logic wr_prot;
    logic addr_err;
    logic unused_inputs;

    assign unused_inputs = ^{hburst, htrans[0]};

    assign accept   = hsel & hreadyin & htrans[1];
    // BASE_ADDR is aligned to the memory size, so the range check reduces
    // to comparing the bits above the word index.
    assign in_range = (haddr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign bad_size = (hsize > 3'b010);
    assign misalign = ((hsize == 3'b001) && haddr[0]) ||
                      ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
`ifdef AHB_SLV_WRITE_PROT_EN
    assign wr_prot  = hwrite && (haddr[AW+1:AW] == 2'b11);
`else
    assign wr_prot  = 1'b0;
`endif
    assign addr_err = ~in_range | bad_size | misalign | wr_prot;

    // Next state chosen from IDLE, DATA and ERR2 (pipelined accept).
    always_comb begin
        accept_state = ST_IDLE;
        if (accept) begin
            if (addr_err)
                accept_state = ST_ERR1;
            else if (WAIT_STATES > 0)
                accept_state = ST_WAIT;
            else
                accept_state = ST_DATA;
        end
    end

    always_ff @(posedge hclk or posedge hresetn) begin
        if (hresetn) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 2'b00;
            wait_cnt  <= 4'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= 2'b00;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= ST_DATA;
                        hreadyout <= 1'b1;
                        hresp     <= 2'b00;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 2'b01;
                end
                default: begin
                    state <= accept_state;
                    if (accept) begin
                        addr_q  <= haddr[AW+1:0];
                        write_q <= hwrite;
                        size_q  <= hsize[1:0];
                    end
                    if (accept_state == ST_WAIT)
                        wait_cnt <= WAIT_LOAD;
                    case (accept_state)
                        ST_WAIT: begin
                            hreadyout <= 1'b0;
                            hresp     <= 2'b00;
                        end
                        ST_ERR1: begin
                            hreadyout <= 1'b0;
                            hresp     <= 2'b01;
                        end
                        default: begin
                            hreadyout <= 1'b1;
                            hresp     <= 2'b00;
                        end
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        case (size_q)
            2'b00:   lane_en = 4'b0001 << addr_q[1:0];
            2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Memory is not reset; an async reset drops state to IDLE, so an
    // interrupted write never reaches this commit.
    always_ff @(posedge hclk) begin
        if ((state == ST_DATA) && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i])
                    mem[addr_q[AW+1:2]][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    // Combinational read so a read following a write sees the committed word.
    assign hrdata = ((state == ST_DATA) && !write_q) ? mem[addr_q[AW+1:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
module tb_ahb_slave_mem;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel1, hsel0;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hburst, hsize;

    logic        hreadyout1, hreadyout0;
    logic        hreadyin1, hreadyin0;
    logic [1:0]  hresp1, hresp0;
    logic [31:0] hrdata1, hrdata0;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    assign hreadyin1 = hreadyout1;
    assign hreadyin0 = hreadyout0;

    always #5 hclk = ~hclk;

    ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .MEM_DEPTH(256), .WAIT_STATES(1)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .htrans(htrans), .hwrite(hwrite),
        .hreadyin(hreadyin1), .haddr(haddr), .hburst(hburst), .hsize(hsize), .hwdata(hwdata),
        .hreadyout(hreadyout1), .hresp(hresp1), .hrdata(hrdata1)
    );

    ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .htrans(htrans), .hwrite(hwrite),
        .hreadyin(hreadyin0), .haddr(haddr), .hburst(hburst), .hsize(hsize), .hwdata(hwdata),
        .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer on the WAIT_STATES=1 instance. Entered and
    // left 1 time unit after a posedge with the slave idle.
    task automatic xfer1(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic [1:0] first_resp, output logic [1:0] resp,
                         output int waits);
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = 2'b10;
        hsel1  = 1'b1;
        @(posedge hclk); #1;
        htrans = 2'b00;
        hsel1  = 1'b0;
        hwdata = wdata;
        first_resp = hresp1;
        waits = 0;
        while (!hreadyout1 && waits < 20) begin
            @(posedge hclk); #1;
            waits++;
        end
        rdata = hrdata1;
        resp  = hresp1;
        @(posedge hclk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  r0, r1;
        int          w;

        hresetn = 1'b1;
        hsel1 = 1'b0; hsel0 = 1'b0;
        htrans = 2'b00; hwrite = 1'b0; haddr = 32'h8000_0000;
        hburst = 3'b000; hsize = 3'b010; hwdata = 32'h0;

        #2;
        chk("rst_hreadyout1", hreadyout1, 1'b1);
        chk("rst_hresp1", hresp1, 2'b00);
        chk("rst_hrdata1", hrdata1, 32'h0);
        chk("rst_hreadyout0", hreadyout0, 1'b1);
        @(posedge hclk); @(posedge hclk); #1;
        hresetn = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge hclk); #1;
            chk("idle_hreadyout", hreadyout1, 1'b1);
            chk("idle_hresp", hresp1, 2'b00);
            chk("idle_hrdata", hrdata1, 32'h0);
        end

        // NONSEQ without hsel, then BUSY with hsel: neither is accepted
        htrans = 2'b10; hsel1 = 1'b0;
        @(posedge hclk); #1;
        chk("nosel_hreadyout", hreadyout1, 1'b1);
        htrans = 2'b01; hsel1 = 1'b1;
        @(posedge hclk); #1;
        chk("busy_hreadyout", hreadyout1, 1'b1);
        chk("busy_hresp", hresp1, 2'b00);
        htrans = 2'b00; hsel1 = 1'b0;
        @(posedge hclk); #1;

        xfer1(32'h8000_0010, 1'b1, 3'b010, 32'hDEAD_BEEF, rd, r0, r1, w);
        chk("wr10_waits", w, 1);
        chk("wr10_resp", r1, 2'b00);
        xfer1(32'h8000_0010, 1'b0, 3'b010, 32'h0, rd, r0, r1, w);
        chk("rd10_waits", w, 1);
        chk("rd10_wait_resp", r0, 2'b00);
        chk("rd10_resp", r1, 2'b00);
        chk("rd10_data", rd, 32'hDEAD_BEEF);

        xfer1(32'h8000_0013, 1'b1, 3'b000, 32'h5A00_0000, rd, r0, r1, w);
        chk("wrb13_resp", r1, 2'b00);
        xfer1(32'h8000_0010, 1'b0, 3'b010, 32'h0, rd, r0, r1, w);
        chk("rd10_after_byte", rd, 32'h5AAD_BEEF);

        xfer1(32'h8000_0010, 1'b1, 3'b001, 32'h0000_1234, rd, r0, r1, w);
        xfer1(32'h8000_0011, 1'b1, 3'b000, 32'h0000_9900, rd, r0, r1, w);
        chk("wrb11_resp", r1, 2'b00);
        xfer1(32'h8000_0010, 1'b0, 3'b010, 32'h0, rd, r0, r1, w);
        chk("rd10_after_half", rd, 32'h5AAD_9934);

        xfer1(32'h8000_0400, 1'b0, 3'b010, 32'h0, rd, r0, r1, w);
        chk("oor_err1_resp", r0, 2'b01);
        chk("oor_err_waits", w, 1);
        chk("oor_err2_resp", r1, 2'b01);
        chk("oor_rdata", rd, 32'h0);
        chk("oor_after_ready", hreadyout1, 1'b1);
        chk("oor_after_resp", hresp1, 2'b00);

        xfer1(32'h7FFF_FFFC, 1'b0, 3'b010, 32'h0, rd, r0, r1, w);
        chk("below_base_resp", r1, 2'b01);
        xfer1(32'h8000_03FC, 1'b1, 3'b010, 32'hA5A5_5A5A, rd, r0, r1, w);
        chk("top_wr_resp", r1, 2'b00);
        xfer1(32'h8000_03FC, 1'b0, 3'b010, 32'h0, rd, r0, r1, w);
        chk("top_rd_resp", r1, 2'b00);
        chk("top_rd_data", rd, 32'hA5A5_5A5A);

        xfer1(32'h8000_0000, 1'b1, 3'b010, 32'h0BAD_F00D, rd, r0, r1, w);
        xfer1(32'h8000_0002, 1'b1, 3'b010, 32'hFFFF_FFFF, rd, r0, r1, w);
        chk("misw_err1_resp", r0, 2'b01);
        chk("misw_err2_resp", r1, 2'b01);
        xfer1(32'h8000_0001, 1'b1, 3'b001, 32'hFFFF_FFFF, rd, r0, r1, w);
        chk("mish_resp", r1, 2'b01);
        xfer1(32'h8000_0000, 1'b1, 3'b011, 32'hFFFF_FFFF, rd, r0, r1, w);
        chk("bigsize_resp", r1, 2'b01);
        xfer1(32'h8000_0000, 1'b0, 3'b010, 32'h0, rd, r0, r1, w);
        chk("rd0_unchanged", rd, 32'h0BAD_F00D);
        chk("rd0_resp", r1, 2'b00);

        // reset during the wait state of a write
        xfer1(32'h8000_0030, 1'b1, 3'b010, 32'h1111_2222, rd, r0, r1, w);
        haddr = 32'h8000_0030; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10; hsel1 = 1'b1;
        @(posedge hclk); #1;
        htrans = 2'b00; hsel1 = 1'b0; hwdata = 32'h3333_4444;
        chk("rstmid_wait_ready", hreadyout1, 1'b0);
        #1 hresetn = 1'b1;
        #1;
        chk("rstmid_ready", hreadyout1, 1'b1);
        chk("rstmid_resp", hresp1, 2'b00);
        chk("rstmid_rdata", hrdata1, 32'h0);
        @(posedge hclk); @(posedge hclk); #1;
        hresetn = 1'b0;
        @(posedge hclk); #1;
        xfer1(32'h8000_0030, 1'b0, 3'b010, 32'h0, rd, r0, r1, w);
        chk("rstmid_keep", rd, 32'h1111_2222);

        // zero-wait instance: pipelined write then read, same address
        haddr = 32'h8000_0020; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10; hsel0 = 1'b1;
        @(posedge hclk); #1;
        chk("ws0_wr_ready", hreadyout0, 1'b1);
        hwdata = 32'h1234_5678; htrans = 2'b11; hwrite = 1'b0;
        @(posedge hclk); #1;
        chk("ws0_rd_ready", hreadyout0, 1'b1);
        chk("ws0_rd_resp", hresp0, 2'b00);
        chk("ws0_rd_data", hrdata0, 32'h1234_5678);
        htrans = 2'b00; hsel0 = 1'b0;
        @(posedge hclk); #1;
        chk("ws0_idle_rdata", hrdata0, 32'h0);
        chk("ws0_idle_ready", hreadyout0, 1'b1);

        // zero-wait instance still gives a two-cycle error
        haddr = 32'h8000_0001; hwrite = 1'b0; hsize = 3'b010; htrans = 2'b10; hsel0 = 1'b1;
        @(posedge hclk); #1;
        htrans = 2'b00; hsel0 = 1'b0;
        chk("ws0_err1_ready", hreadyout0, 1'b0);
        chk("ws0_err1_resp", hresp0, 2'b01);
        @(posedge hclk); #1;
        chk("ws0_err2_ready", hreadyout0, 1'b1);
        chk("ws0_err2_resp", hresp0, 2'b01);
        @(posedge hclk); #1;
        chk("ws0_post_resp", hresp0, 2'b00);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
